// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the kiwi sub-CPU shared-RAM bridge.
// Optional contention support: JTKIWI_SHR_CONTENTION_EN.
package jtkiwi_pkg;

  localparam logic [2:0] SHR_BASE_DEF  = 3'b110;
  localparam int         MAX_DEFER_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_LATCH,
`ifdef JTKIWI_SHR_CONTENTION_EN
    ST_HOLD,
    ST_DEFER
`else
    ST_HOLD
`endif
  } shr_st_e;

endpackage

// File: rtl/jtkiwi_shr_bridge_if.sv
// Sub-CPU bus and shared-RAM port-1 signal bundle.
// slave = bridge view, master = system/CPU view.
interface jtkiwi_shr_bridge_if;

  logic        snd_rstn;
  logic [15:0] A;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        wait_n;
  logic [12:0] shr_addr;
  logic [7:0]  shr_din;
  logic        shr_we;
  logic [7:0]  shr_dout;
  logic        main_busy;

  modport slave (
    input  snd_rstn, A, mreq_n, rd_n, wr_n,
    input  cpu_dout, shr_dout, main_busy,
    output cpu_din, wait_n,
    output shr_addr, shr_din, shr_we
  );

  modport master (
    output snd_rstn, A, mreq_n, rd_n, wr_n,
    output cpu_dout, shr_dout, main_busy,
    input  cpu_din, wait_n,
    input  shr_addr, shr_din, shr_we
  );

endinterface

// File: rtl/jtkiwi_shr_defer.sv
// Saturating deferral counter for main-CPU contention.
// Only built with JTKIWI_SHR_CONTENTION_EN.
module jtkiwi_shr_defer #(
  parameter int MAX_DEFER = 15
)(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_exp
);

  localparam int W = $clog2(MAX_DEFER + 1);

  logic [W-1:0] r_cnt;

  // Flags one clk early so the last busy DEFER clk is the exit clk
  assign o_exp = r_cnt >= W'(MAX_DEFER - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && r_cnt != W'(MAX_DEFER)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtkiwi_shr_bridge.sv
// Sub-CPU to shared-RAM bridge with Z80 wait handshake.
// Optional main-CPU contention deferral: JTKIWI_SHR_CONTENTION_EN.
module jtkiwi_shr_bridge
  import jtkiwi_pkg::*;
#(
  parameter logic [2:0] SHR_BASE  = SHR_BASE_DEF,
  parameter int         MAX_DEFER = MAX_DEFER_DEF
)(
  input  logic                clk,
  input  logic                rst,
  jtkiwi_shr_bridge_if.slave  bus
);

  shr_st_e     r_st;
  shr_st_e     w_nxt;
  logic        w_sel;
  logic        w_wr;
  logic [12:0] r_addr;
  logic [7:0]  r_din;
  logic [7:0]  r_cpu_din;

  assign w_sel = bus.snd_rstn & ~bus.mreq_n &
                 (bus.A[15:13] == SHR_BASE) &
                 (~bus.rd_n | ~bus.wr_n);
  assign w_wr  = ~bus.wr_n;

`ifdef JTKIWI_SHR_CONTENTION_EN
  logic r_wr;
  logic w_exp;

  jtkiwi_shr_defer #(
    .MAX_DEFER (MAX_DEFER)
  ) u_defer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_st != ST_DEFER || w_nxt != ST_DEFER),
    .i_inc (r_st == ST_DEFER && bus.main_busy),
    .o_exp (w_exp)
  );
`else
  logic w_unused;
  assign w_unused = bus.main_busy ^ (MAX_DEFER == 0);
`endif

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      ST_IDLE: begin
        if (w_sel) begin
          w_nxt = w_wr ? ST_WR : ST_RD_ADDR;
`ifdef JTKIWI_SHR_CONTENTION_EN
          if (bus.main_busy) w_nxt = ST_DEFER;
`endif
        end
      end
      ST_WR:       w_nxt = ST_HOLD;
      ST_RD_ADDR:  w_nxt = ST_RD_LATCH;
      ST_RD_LATCH: w_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!w_sel) w_nxt = ST_IDLE;
      end
`ifdef JTKIWI_SHR_CONTENTION_EN
      ST_DEFER: begin
        if (!bus.main_busy || w_exp)
          w_nxt = r_wr ? ST_WR : ST_RD_ADDR;
      end
`endif
      default:     w_nxt = ST_IDLE;
    endcase
    if (!bus.snd_rstn) w_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= ST_IDLE;
      r_addr    <= '0;
      r_din     <= '0;
      r_cpu_din <= 8'hFF;
`ifdef JTKIWI_SHR_CONTENTION_EN
      r_wr      <= 1'b0;
`endif
    end else begin
      r_st <= w_nxt;
      if (r_st == ST_IDLE && w_sel) begin
        r_addr <= bus.A[12:0];
        r_din  <= bus.cpu_dout;
`ifdef JTKIWI_SHR_CONTENTION_EN
        r_wr   <= w_wr;
`endif
      end
      if (r_st == ST_RD_LATCH && bus.snd_rstn)
        r_cpu_din <= bus.shr_dout;
    end
  end

  assign bus.shr_addr = r_addr;
  assign bus.shr_din  = r_din;
  assign bus.shr_we   = (r_st == ST_WR) & bus.snd_rstn;
  assign bus.cpu_din  = r_cpu_din;
  assign bus.wait_n   = ~(w_sel & (r_st != ST_HOLD));

endmodule

// File: tb/tb_jtkiwi_shr_bridge.sv
// Self-checking bench for jtkiwi_shr_bridge with a registered RAM model.
// Contention cases run when JTKIWI_SHR_CONTENTION_EN is defined.
module tb_jtkiwi_shr_bridge;

  typedef struct packed {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  jtkiwi_shr_bridge_if bus ();

  jtkiwi_shr_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:8191];
  logic        pl_en;
  logic [12:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.shr_we) ram[bus.shr_addr] <= bus.shr_din;
    bus.shr_dout <= ram[bus.shr_addr];
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model [0:8191];
  wr_t         exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  last_din;

  int          wlow, nwe, we_at;
  logic [12:0] wa;
  logic [7:0]  wd, din3;
  wr_t         ew;
  logic [7:0]  er;

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    model[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic release_bus();
    bus.mreq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
  endtask

  // Drives one access for a fixed window and records what the DUT did
  task automatic run_access(
    input  bit          wr,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    input  int          ncyc,
    input  int          rel_at,
    input  int          drop_at,
    output int          o_wlow,
    output int          o_nwe,
    output int          o_we_at,
    output logic [12:0] o_wa,
    output logic [7:0]  o_wd,
    output logic [7:0]  o_din3
  );
    o_wlow = 0; o_nwe = 0; o_we_at = -1;
    o_wa = '0; o_wd = '0; o_din3 = '0;
    @(posedge clk); #1;
    bus.A = a; bus.cpu_dout = d;
    bus.mreq_n = 1'b0;
    bus.rd_n = wr ? 1'b1 : 1'b0;
    bus.wr_n = wr ? 1'b0 : 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == rel_at) release_bus();
      if (c == drop_at) bus.main_busy = 1'b0;
      @(negedge clk);
      if (!bus.wait_n) o_wlow++;
      if (bus.shr_we) begin
        o_nwe++; o_we_at = c;
        o_wa = bus.shr_addr; o_wd = bus.shr_din;
      end
      if (c == 3) o_din3 = bus.cpu_din;
    end
    release_bus();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.snd_rstn = 1'b1; bus.A = '0; bus.cpu_dout = '0;
    bus.main_busy = 1'b0;
    release_bus();
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    @(negedge clk);
    n_tests++;
    if (bus.wait_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_wait_n got %b exp 1", bus.wait_n);
    end
    n_tests++;
    if (bus.shr_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_we got %b exp 0", bus.shr_we);
    end
    n_tests++;
    if (bus.cpu_din !== 8'hFF) begin
      n_fail++; $display("FAIL reset_cpu_din got %h exp ff", bus.cpu_din);
    end
    n_tests++;
    if (bus.shr_addr !== 13'h0 || bus.shr_din !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_addr_din got %h/%h exp 0/0",
               bus.shr_addr, bus.shr_din);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_din = 8'hFF;
  endtask

  task automatic test_write();
    exp_wr.push_back('{a: 13'h0123, d: 8'h5A});
    model[13'h0123] = 8'h5A;
    run_access(1'b1, 16'hC123, 8'h5A, 5, 3, -1,
               wlow, nwe, we_at, wa, wd, din3);
    ew = exp_wr.pop_front();
    n_tests++;
    if (nwe !== 1 || we_at !== 1) begin
      n_fail++;
      $display("FAIL write_pulse got n=%0d at=%0d exp n=1 at=1", nwe, we_at);
    end
    n_tests++;
    if (wa !== ew.a || wd !== ew.d) begin
      n_fail++;
      $display("FAIL write_data got %h/%h exp %h/%h", wa, wd, ew.a, ew.d);
    end
    n_tests++;
    if (wlow !== 2) begin
      n_fail++; $display("FAIL write_wait got %0d exp 2", wlow);
    end
  endtask

  task automatic test_read();
    preload(13'h1FFF, 8'hA7);
    exp_rd.push_back(model[13'h1FFF]);
    run_access(1'b0, 16'hDFFF, 8'h00, 6, 4, -1,
               wlow, nwe, we_at, wa, wd, din3);
    er = exp_rd.pop_front();
    n_tests++;
    if (din3 !== er) begin
      n_fail++; $display("FAIL read_data got %h exp %h", din3, er);
    end
    n_tests++;
    if (wlow !== 3 || nwe !== 0) begin
      n_fail++;
      $display("FAIL read_wait got wlow=%0d we=%0d exp 3/0", wlow, nwe);
    end
    last_din = er;
  endtask

  task automatic test_outside();
    run_access(1'b0, 16'h8000, 8'h00, 3, 2, -1,
               wlow, nwe, we_at, wa, wd, din3);
    n_tests++;
    if (wlow !== 0 || nwe !== 0) begin
      n_fail++;
      $display("FAIL outside_access got wlow=%0d we=%0d exp 0/0", wlow, nwe);
    end
    n_tests++;
    if (bus.cpu_din !== last_din) begin
      n_fail++;
      $display("FAIL outside_din got %h exp %h", bus.cpu_din, last_din);
    end
  endtask

  task automatic test_snd_rstn();
    int hi_cnt, we_cnt;
    preload(13'h0010, 8'h5C);
    @(posedge clk); #1;
    bus.A = 16'hC010; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.wait_n !== 1'b0) begin
      n_fail++; $display("FAIL sndrst_stall got %b exp 0", bus.wait_n);
    end
    @(posedge clk); #1;
    bus.snd_rstn = 1'b0;
    hi_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.wait_n) hi_cnt++;
      if (bus.shr_we) we_cnt++;
      @(posedge clk); #1;
      if (i == 1) bus.wr_n = 1'b0;
    end
    n_tests++;
    if (hi_cnt !== 5 || we_cnt !== 0) begin
      n_fail++;
      $display("FAIL sndrst_idle got hi=%0d we=%0d exp 5/0", hi_cnt, we_cnt);
    end
    n_tests++;
    if (bus.cpu_din !== last_din) begin
      n_fail++;
      $display("FAIL sndrst_din got %h exp %h", bus.cpu_din, last_din);
    end
    release_bus();
    @(posedge clk); #1;
    bus.snd_rstn = 1'b1;
    exp_rd.push_back(model[13'h0010]);
    run_access(1'b0, 16'hC010, 8'h00, 6, 4, -1,
               wlow, nwe, we_at, wa, wd, din3);
    er = exp_rd.pop_front();
    n_tests++;
    if (din3 !== er || wlow !== 3) begin
      n_fail++;
      $display("FAIL sndrst_recover got %h/%0d exp %h/3", din3, wlow, er);
    end
    last_din = er;
  endtask

  task automatic test_hold();
    preload(13'h0200, 8'h3E);
    exp_rd.push_back(model[13'h0200]);
    run_access(1'b0, 16'hC200, 8'h00, 12, 10, -1,
               wlow, nwe, we_at, wa, wd, din3);
    er = exp_rd.pop_front();
    n_tests++;
    if (wlow !== 3 || nwe !== 0 || din3 !== er) begin
      n_fail++;
      $display("FAIL hold_single got wlow=%0d we=%0d d=%h exp 3/0/%h",
               wlow, nwe, din3, er);
    end
    last_din = er;
    exp_wr.push_back('{a: 13'h0201, d: 8'hC3});
    model[13'h0201] = 8'hC3;
    run_access(1'b1, 16'hC201, 8'hC3, 5, 3, -1,
               wlow, nwe, we_at, wa, wd, din3);
    ew = exp_wr.pop_front();
    n_tests++;
    if (nwe !== 1 || we_at !== 1 || wlow !== 2 ||
        wa !== ew.a || wd !== ew.d) begin
      n_fail++;
      $display("FAIL hold_next got n=%0d at=%0d w=%0d %h/%h exp 1/1/2 %h/%h",
               nwe, we_at, wlow, wa, wd, ew.a, ew.d);
    end
  endtask

  task automatic test_back_to_back();
    exp_rd.push_back(model[13'h0201]);
    run_access(1'b0, 16'hC201, 8'h00, 6, 4, -1,
               wlow, nwe, we_at, wa, wd, din3);
    er = exp_rd.pop_front();
    n_tests++;
    if (din3 !== er || wlow !== 3) begin
      n_fail++;
      $display("FAIL b2b_readback got %h/%0d exp %h/3", din3, wlow, er);
    end
    last_din = er;
  endtask

  task automatic test_abort();
    exp_wr.push_back('{a: 13'h0050, d: 8'h99});
    model[13'h0050] = 8'h99;
    run_access(1'b1, 16'hC050, 8'h99, 4, 1, -1,
               wlow, nwe, we_at, wa, wd, din3);
    ew = exp_wr.pop_front();
    n_tests++;
    if (nwe !== 1 || wa !== ew.a || wd !== ew.d || wlow !== 1) begin
      n_fail++;
      $display("FAIL abort_write got n=%0d %h/%h w=%0d exp 1 %h/%h 1",
               nwe, wa, wd, wlow, ew.a, ew.d);
    end
    exp_rd.push_back(model[13'h0050]);
    run_access(1'b0, 16'hC050, 8'h00, 5, 1, -1,
               wlow, nwe, we_at, wa, wd, din3);
    er = exp_rd.pop_front();
    n_tests++;
    if (din3 !== er || wlow !== 1) begin
      n_fail++;
      $display("FAIL abort_read got %h/%0d exp %h/1", din3, wlow, er);
    end
    last_din = er;
  endtask

  task automatic test_contention();
    bus.main_busy = 1'b1;
    exp_wr.push_back('{a: 13'h0300, d: 8'h11});
    model[13'h0300] = 8'h11;
`ifdef JTKIWI_SHR_CONTENTION_EN
    run_access(1'b1, 16'hC300, 8'h11, 20, 18, -1,
               wlow, nwe, we_at, wa, wd, din3);
    ew = exp_wr.pop_front();
    n_tests++;
    if (nwe !== 1 || we_at !== 16 || wlow !== 17 || wd !== ew.d) begin
      n_fail++;
      $display("FAIL defer_max got n=%0d at=%0d w=%0d d=%h exp 1/16/17/%h",
               nwe, we_at, wlow, wd, ew.d);
    end
    bus.main_busy = 1'b1;
    exp_wr.push_back('{a: 13'h0301, d: 8'h22});
    model[13'h0301] = 8'h22;
    run_access(1'b1, 16'hC301, 8'h22, 9, 7, 4,
               wlow, nwe, we_at, wa, wd, din3);
    ew = exp_wr.pop_front();
    n_tests++;
    if (nwe !== 1 || we_at !== 5 || wa !== ew.a || wd !== ew.d) begin
      n_fail++;
      $display("FAIL defer_drop got n=%0d at=%0d %h/%h exp 1/5 %h/%h",
               nwe, we_at, wa, wd, ew.a, ew.d);
    end
`else
    run_access(1'b1, 16'hC300, 8'h11, 5, 3, -1,
               wlow, nwe, we_at, wa, wd, din3);
    ew = exp_wr.pop_front();
    n_tests++;
    if (nwe !== 1 || we_at !== 1 || wlow !== 2 || wd !== ew.d) begin
      n_fail++;
      $display("FAIL busy_ignored got n=%0d at=%0d w=%0d d=%h exp 1/1/2/%h",
               nwe, we_at, wlow, wd, ew.d);
    end
`endif
    bus.main_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_outside();
    test_snd_rstn();
    test_hold();
    test_back_to_back();
    test_abort();
    test_contention();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
